// File: rtl/output_arbiter.sv
// output_arbiter
//   Wormhole output-port arbiter for a 5-port mesh router. One input port
//   at a time owns the output from its head flit until its tail flit has
//   crossed the crossbar. The next owner is picked round-robin, starting
//   just above the port that finished most recently.
//
// Parameters
//   RR_INIT    : port index (0..4) with highest priority after reset
//   CNT_WIDTH  : width of the completed-packet counter
//
// Ports (bit order of every 5-bit vector: 0=N, 1=E, 2=W, 3=S, 4=L)
//   clk        : clock, rising edge active
//   rst        : asynchronous reset, active low
//   req_in     : flit available at the head of each input FIFO
//   tail_in    : head flit of each input FIFO is a tail flit
//   dest_ready : downstream neighbour accepts one flit this cycle
//   sel_out    : registered crossbar select, one-hot or zero
//   grant_out  : pop strobe to the owning input FIFO
//   valid_out  : a flit crosses the crossbar this cycle
//   pkt_count  : number of completed packets, wraps silently
module output_arbiter #(
  parameter int RR_INIT   = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           req_in,
  input  logic [4:0]           tail_in,
  input  logic                 dest_ready,
  output logic [4:0]           sel_out,
  output logic [4:0]           grant_out,
  output logic                 valid_out,
  output logic [CNT_WIDTH-1:0] pkt_count
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t               r_state;
  logic [4:0]           r_sel;
  logic [2:0]           r_rrPtr;
  logic [2:0]           r_owner;
  logic [CNT_WIDTH-1:0] r_pktCount;

  logic [4:0] w_grant;
  logic       w_tailDone;
  logic [2:0] w_nextPtr;
  logic [2:0] w_pickIdx;
  logic       w_pickFound;
  logic [3:0] w_sum;
  logic [2:0] w_candIdx;

  // Round-robin search: walk the five ports circularly upward starting at
  // the priority pointer and take the first one that is requesting.
  always_comb begin
    w_pickIdx   = 3'd0;
    w_pickFound = 1'b0;
    w_sum       = 4'd0;
    w_candIdx   = 3'd0;
    for (int k = 0; k < 5; k++) begin
      w_sum     = {1'b0, r_rrPtr} + 4'(k);
      w_candIdx = (w_sum >= 4'd5) ? 3'(w_sum - 4'd5) : 3'(w_sum);
      if (!w_pickFound && req_in[w_candIdx]) begin
        w_pickIdx   = w_candIdx;
        w_pickFound = 1'b1;
      end
    end
  end

  // The select register is zero while idle, so the grant can only ever
  // reach the current owner and never fires before ownership is taken.
  assign w_grant    = r_sel & req_in & {5{dest_ready}};
  assign w_tailDone = (|w_grant) & (|(r_sel & tail_in));
  assign w_nextPtr  = (r_owner == 3'd4) ? 3'd0 : r_owner + 3'd1;

  // Ownership FSM. A completed tail always drops back to IDLE, which gives
  // the fixed one-cycle bubble before the next arbitration. Stalls
  // (dest_ready low) and an owner that stops requesting simply leave the
  // lock in place because no tail can transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_sel      <= 5'd0;
      r_rrPtr    <= 3'(RR_INIT);
      r_owner    <= 3'd0;
      r_pktCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pickFound) begin
            r_sel   <= 5'b00001 << w_pickIdx;
            r_owner <= w_pickIdx;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_tailDone) begin
            r_sel      <= 5'd0;
            r_rrPtr    <= w_nextPtr;
            r_pktCount <= r_pktCount + 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_sel   <= 5'd0;
        end
      endcase
    end
  end

  assign sel_out   = r_sel;
  assign grant_out = w_grant;
  assign valid_out = |w_grant;
  assign pkt_count = r_pktCount;

endmodule

// File: doc/output_arbiter.md
OUTPUT_ARBITER -- requirements
Module: output_arbiter

Interface
REQ-001 SHALL take parameter RR_INIT, default 0, meaning the index (0..4) that has highest priority after reset.
REQ-002 SHALL take parameter CNT_WIDTH, default 16, meaning the width of the packet counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_in, input, 5 bits: the flit-available request from each input FIFO; bit 0=N, 1=E, 2=W, 3=S, 4=L.
REQ-006 SHALL have port tail_in, input, 5 bits: asserted when the flit at the head of that input FIFO is a tail flit; same bit order as req_in.
REQ-007 SHALL have port dest_ready, input, 1 bit: the downstream neighbour can accept one flit this cycle.
REQ-008 SHALL have port sel_out, output, 5 bits: one-hot or all-zero crossbar select; same bit order as req_in.
REQ-009 SHALL have port grant_out, output, 5 bits: one-hot read-enable (pop) to the input FIFOs.
REQ-010 SHALL have port valid_out, output, 1 bit: a flit is transferred through the crossbar this cycle.
REQ-011 SHALL have port pkt_count, output, CNT_WIDTH bits: the number of completed packets.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, in which no port is owned, and LOCKED, in which one port owns the output.
REQ-013 In IDLE with req_in != 0, SHALL select the first set bit searching circularly upward from rr_ptr, register it into sel_out, and enter LOCKED at the next edge; the latency from request to sel_out is 1 cycle.
REQ-014 In IDLE with req_in == 0, SHALL remain in IDLE with sel_out = 0.
REQ-015 In LOCKED, sel_out SHALL hold its value regardless of other requests.
REQ-016 grant_out SHALL be combinational: sel_out & req_in & {5{dest_ready}}.
REQ-017 valid_out SHALL be the OR-reduction of grant_out.
REQ-018 A transfer SHALL be any cycle in which valid_out = 1.
REQ-019 A transfer in which tail_in of the selected port = 1 SHALL complete the packet. At the next edge:
- state returns to IDLE;
- sel_out becomes 0;
- rr_ptr becomes (selected index + 1) mod 5;
- pkt_count increments by 1.
REQ-020 A single-flit packet (head flit also tail) SHALL complete on its first transfer.
REQ-021 If the owner drops req_in while LOCKED, SHALL stay LOCKED with no grant (wormhole lock held) until its tail transfers.
REQ-022 If dest_ready = 0, SHALL issue no grant and leave state, sel_out and rr_ptr unchanged.
REQ-023 pkt_count SHALL wrap from 2^CNT_WIDTH-1 to 0 without flag.
REQ-024 tail_in of non-selected ports SHALL be ignored.
REQ-025 grant_out SHALL never have more than one bit set.
REQ-026 grant_out SHALL never be set in IDLE.
REQ-027 A new arbitration always costs one IDLE cycle after a tail (fixed one-cycle bubble).

Reset
REQ-028 While rst = 0, SHALL asynchronously force:
- state = IDLE;
- sel_out = 0;
- rr_ptr = RR_INIT;
- pkt_count = 0.
Consequently grant_out = 0 and valid_out = 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet with no count increment.
REQ-030 Arbitration SHALL restart on the first rising clk edge after rst deasserts.

Verification
REQ-031 Reset then req_in=00001, tail_in=00001, dest_ready=1 -> cycle 1: sel_out=00001; grant_out=00001 and valid_out=1 in cycle 1; cycle 2: sel_out=0, pkt_count=1.
REQ-032 req_in=11111 held, every flit a tail, dest_ready=1 -> owners in order N,E,W,S,L,N; each owner is separated by one IDLE cycle.
REQ-033 E owns a 4-flit packet; dest_ready=0 on flits 2-3 -> grant_out=0 during the stall, sel_out held at 00010; tail transfers on the 6th LOCKED cycle; pkt_count+1.
REQ-034 W owns a packet and drops req_in for 2 cycles while L requests -> sel_out stays 00100; no grant to L until W's tail completes.
REQ-035 rst pulsed low mid-packet of S -> outputs are 0 immediately without a clock edge; after release, highest priority is RR_INIT; pkt_count=0.
REQ-036 CNT_WIDTH=4 with 17 single-flit packets -> pkt_count=1 after wrap.
